// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative shift-add multiplier / restoring divider with HI/LO
//            registers and a start/busy/done handshake.
//            Define MULDIV_DIV_EN to compile in the DIVU/DIV datapath.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int         c_CNT_W   = $clog2(WIDTH);
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CALC    = 2'd1;
    localparam logic [1:0] c_FIX     = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;
    localparam logic [1:0] c_OP_MULT = 2'b01;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_open;
    logic               w_op_ok;
    logic               w_launch;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0]   r_b;
    logic               r_dbz;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;

    assign w_op_ok = 1'b1;
`else
    assign w_op_ok = !op[1];
`endif

    assign w_open   = (r_state == c_IDLE) || (r_state == c_DONE);
    assign w_launch = start && w_open && w_op_ok;

    // Signed ops iterate on magnitudes; the most-negative value maps to 2^(W-1).
    assign w_a_mag = (op[0] && a_in[WIDTH-1]) ? -a_in : a_in;
    assign w_b_mag = (op[0] && b_in[WIDTH-1]) ? -b_in : b_in;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_launch) w_state_next = c_CALC;
            c_CALC:  if (r_cnt == '0) w_state_next = c_FIX;
            c_FIX:   w_state_next = c_DONE;
            c_DONE:  w_state_next = w_launch ? c_CALC : c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_IDLE;
        else      r_state <= w_state_next;
    end

    // One iteration: multiply shifts the sum right, divide shifts the remainder left.
    always_comb begin
        w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                  + (r_prod[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
        w_step    = {w_mul_sum, r_prod[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        w_div_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
        w_div_ge    = w_div_shift >= {1'b0, r_b};
        w_div_rem   = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_b) : w_div_shift[WIDTH-1:0];
        if (r_op[1]) w_step = {w_div_rem, r_prod[WIDTH-2:0], w_div_ge};
`endif
    end

    always_comb begin
        w_prod_fix = ((r_op == c_OP_MULT) && (r_sign_a ^ r_sign_b)) ? -r_prod : r_prod;
        w_hi_res   = w_prod_fix[2*WIDTH-1:WIDTH];
        w_lo_res   = w_prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (r_op[1]) begin
            if (r_dbz) begin
                w_lo_res = '1;
                w_hi_res = r_sign_a ? -r_a : r_a;
            end else begin
                w_lo_res = (r_sign_a ^ r_sign_b) ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
                w_hi_res = r_sign_a ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MULDIV_DIV_EN
            r_b      <= '0;
            r_dbz    <= 1'b0;
`endif
        end else begin
            if (w_launch) begin
                r_op     <= op;
                r_a      <= w_a_mag;
                r_sign_a <= op[0] && a_in[WIDTH-1];
                r_sign_b <= op[0] && b_in[WIDTH-1];
                r_cnt    <= c_CNT_W'(WIDTH-1);
                r_prod   <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
`ifdef MULDIV_DIV_EN
                r_b      <= w_b_mag;
                r_dbz    <= op[1] && (b_in == '0);
`endif
            end else if (r_state == c_CALC) begin
                r_prod <= w_step;
                r_cnt  <= r_cnt - c_CNT_W'(1);
            end

            // An accepted start takes priority over a same-edge MT write.
            if (r_state == c_FIX) begin
                r_hi <= w_hi_res;
                r_lo <= w_lo_res;
            end else if (w_open && !w_launch) begin
                if (mthi) r_hi <= wdata;
                if (mtlo) r_lo <= wdata;
            end
        end
    end

    assign busy   = (r_state == c_CALC) || (r_state == c_FIX);
    assign done   = (r_state == c_DONE);
    assign hi_out = r_hi;
    assign lo_out = r_lo;
`ifdef MULDIV_DIV_EN
    assign div_by_zero = done && r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule
`default_nettype wire
